// File: rtl/array_rf_sched.sv
// Refresh scheduler: interval ticker, postponed-refresh debt counter and a
// request/start/wait handshake toward the array arbiter and refresh sequencer.
module array_rf_sched #(
    parameter int TREFI_WIDTH = 16,
    parameter int DEBT_MAX    = 8,
    parameter int URGENT_TH   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rf_en,
    input  logic [TREFI_WIDTH-1:0] array_tREFI,
    output logic                   rf_req,
    input  logic                   rf_gnt,
    output logic                   rf_urgent,
    output logic                   array_rf_start,
    input  logic                   array_rf_done,
    output logic                   rf_busy,
    output logic [3:0]             rf_debt,
    output logic                   rf_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [TREFI_WIDTH-1:0] L_ONE      = TREFI_WIDTH'(1);
    localparam logic [TREFI_WIDTH-1:0] L_ZERO     = '0;
    localparam logic [3:0]             L_DEBT_MAX = 4'(DEBT_MAX);
    localparam logic [3:0]             L_URGENT   = 4'(URGENT_TH);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TREFI_WIDTH-1:0] r_cnt;
    logic [TREFI_WIDTH-1:0] w_reload;
    logic [3:0]             r_debt;
    logic [3:0]             w_debt_nxt;
    logic                   r_ovf;
    logic                   w_ovf_set;
    logic                   w_tick;
    logic                   w_done_acc;

    // A zero interval reloads to all-ones but never ticks.
    assign w_reload   = array_tREFI - L_ONE;
    assign w_tick     = rf_en && (r_cnt == L_ZERO) && (array_tREFI != L_ZERO);
    assign w_done_acc = (r_state == ST_WAIT) && array_rf_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= L_ZERO;
        end else if (!rf_en || (r_cnt == L_ZERO)) begin
            r_cnt <= w_reload;
        end else begin
            r_cnt <= r_cnt - L_ONE;
        end
    end

    always_comb begin
        w_debt_nxt = r_debt;
        w_ovf_set  = 1'b0;
        if (w_tick && !w_done_acc) begin
            if (r_debt == L_DEBT_MAX) begin
                w_ovf_set = 1'b1;
            end else begin
                w_debt_nxt = r_debt + 4'd1;
            end
        end else if (!w_tick && w_done_acc && (r_debt != 4'd0)) begin
            w_debt_nxt = r_debt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_debt <= 4'd0;
            r_ovf  <= 1'b0;
        end else begin
            r_debt <= w_debt_nxt;
            r_ovf  <= r_ovf | w_ovf_set;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping rf_en only abandons a pending request; a started sequence runs to done.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (rf_en && (r_debt != 4'd0)) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (!rf_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (rf_gnt) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (array_rf_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign rf_req         = (r_state == ST_REQ);
    assign array_rf_start = (r_state == ST_START);
    assign rf_busy        = (r_state == ST_START) || (r_state == ST_WAIT);
    assign rf_urgent      = (r_debt >= L_URGENT);
    assign rf_debt        = r_debt;
    assign rf_overflow    = r_ovf;

endmodule

// File: tb/tb_array_rf_sched.sv
// Directed bench for array_rf_sched: a cycle table for the basic handshake
// plus hand-written sequences for periodic refresh, overflow, collisions and reset.
module tb_array_rf_sched;

    logic        clk;
    logic        rst;
    logic        rf_en;
    logic [15:0] array_tREFI;
    logic        rf_req;
    logic        rf_gnt;
    logic        rf_urgent;
    logic        array_rf_start;
    logic        array_rf_done;
    logic        rf_busy;
    logic [3:0]  rf_debt;
    logic        rf_overflow;

    int total;
    int bad;

    array_rf_sched #(
        .TREFI_WIDTH(16),
        .DEBT_MAX(8),
        .URGENT_TH(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rf_en(rf_en),
        .array_tREFI(array_tREFI),
        .rf_req(rf_req),
        .rf_gnt(rf_gnt),
        .rf_urgent(rf_urgent),
        .array_rf_start(array_rf_start),
        .array_rf_done(array_rf_done),
        .rf_busy(rf_busy),
        .rf_debt(rf_debt),
        .rf_overflow(rf_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       gnt;
        logic       done;
        logic       req;
        logic       start;
        logic       busy;
        logic [3:0] debt;
    } vec_t;

    vec_t tbl[16];

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic applyStimulus(input logic en, input logic gnt, input logic done);
        rf_en         = en;
        rf_gnt        = gnt;
        array_rf_done = done;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [15:0] trefi);
        rf_en         = 1'b0;
        rf_gnt        = 1'b0;
        array_rf_done = 1'b0;
        array_tREFI   = trefi;
        rst           = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int lastStart;
        int starts;
        int maxDebt;
        bit drained;
        bit sawReq;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        rf_en = 1'b0;
        rf_gnt = 1'b0;
        array_rf_done = 1'b0;
        array_tREFI = 16'd3;

        // en gnt done | req start busy debt   (tREFI=3, first tick on 3rd enabled edge)
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 4'd0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 4'd0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 4'd1};
        tbl[3]  = '{1, 0, 0, 1, 0, 0, 4'd1};
        tbl[4]  = '{1, 1, 0, 0, 1, 1, 4'd1};
        tbl[5]  = '{1, 1, 0, 0, 0, 1, 4'd2};
        tbl[6]  = '{1, 0, 1, 0, 0, 0, 4'd1};
        tbl[7]  = '{1, 0, 0, 1, 0, 0, 4'd1};
        tbl[8]  = '{1, 0, 0, 1, 0, 0, 4'd2};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 4'd2};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 4'd2};
        tbl[11] = '{1, 1, 0, 1, 0, 0, 4'd2};
        tbl[12] = '{1, 1, 0, 0, 1, 1, 4'd2};
        tbl[13] = '{0, 0, 0, 0, 0, 1, 4'd2};
        tbl[14] = '{0, 0, 1, 0, 0, 0, 4'd1};
        tbl[15] = '{0, 1, 0, 0, 0, 0, 4'd1};

        doReset(16'd3);
        checkOutput("reset_req", rf_req, 0);
        checkOutput("reset_start", array_rf_start, 0);
        checkOutput("reset_busy", rf_busy, 0);
        checkOutput("reset_debt", rf_debt, 0);
        checkOutput("reset_urgent", rf_urgent, 0);
        checkOutput("reset_ovf", rf_overflow, 0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].en, tbl[i].gnt, tbl[i].done);
            checkOutput($sformatf("tbl%0d_req", i), rf_req, tbl[i].req);
            checkOutput($sformatf("tbl%0d_start", i), array_rf_start, tbl[i].start);
            checkOutput($sformatf("tbl%0d_busy", i), rf_busy, tbl[i].busy);
            checkOutput($sformatf("tbl%0d_debt", i), rf_debt, tbl[i].debt);
        end

        // Periodic refresh: tREFI=100, grant tied high, done 10 cycles after each start.
        $display("[TB] periodic refresh");
        doReset(16'd100);
        lastStart = -1;
        starts    = 0;
        maxDebt   = 0;
        for (int k = 1; k <= 310; k++) begin
            applyStimulus(1'b1, 1'b1, (lastStart >= 0) && (k - lastStart == 10));
            if (rf_debt > maxDebt) maxDebt = rf_debt;
            if (array_rf_start) begin
                if (lastStart < 0) checkOutput("periodic_first_start", k, 102);
                else checkOutput("periodic_spacing", k - lastStart, 100);
                lastStart = k;
                starts++;
            end
        end
        checkOutput("periodic_starts", starts, 3);
        checkOutput("periodic_maxdebt", maxDebt, 1);
        checkOutput("periodic_ovf", rf_overflow, 0);

        // Debt build-up without grant, then drain with immediate grant and done.
        $display("[TB] overflow and drain");
        doReset(16'd10);
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (k == 59) begin
                checkOutput("ovf_debt5", rf_debt, 5);
                checkOutput("ovf_urgent_off", rf_urgent, 0);
            end
            if (k == 60) begin
                checkOutput("ovf_debt6", rf_debt, 6);
                checkOutput("ovf_urgent_on", rf_urgent, 1);
            end
            if (k == 80) begin
                checkOutput("ovf_debt8", rf_debt, 8);
                checkOutput("ovf_not_yet", rf_overflow, 0);
            end
            if (k == 89) checkOutput("ovf_before_tick9", rf_overflow, 0);
            if (k == 90) begin
                checkOutput("ovf_after_tick9", rf_overflow, 1);
                checkOutput("ovf_debt_sat", rf_debt, 8);
            end
        end
        checkOutput("ovf_req_held", rf_req, 1);
        checkOutput("ovf_debt_final", rf_debt, 8);
        lastStart = -1;
        starts    = 0;
        drained   = 1'b0;
        for (int k = 1; k <= 300 && !drained; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (array_rf_start) begin
                if (lastStart >= 0) checkOutput("drain_spacing", k - lastStart, 4);
                lastStart = k;
                starts++;
            end
            if (rf_debt == 4'd0 && !rf_busy) drained = 1'b1;
        end
        checkOutput("drain_done", drained, 1);
        checkOutput("drain_min_starts", (starts >= 8), 1);
        checkOutput("drain_ovf_sticky", rf_overflow, 1);
        checkOutput("drain_urgent_off", rf_urgent, 0);

        // Tick and done in the same cycle at debt 3: tREFI=5, ticks on edges 5,10,15,20.
        $display("[TB] tick/done collision");
        doReset(16'd5);
        for (int k = 1; k <= 15; k++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("coll_debt3", rf_debt, 3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("coll_start", array_rf_start, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("coll_wait_busy", rf_busy, 1);
        checkOutput("coll_wait_debt", rf_debt, 3);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("coll_same_cycle_debt", rf_debt, 3);
        checkOutput("coll_idle", rf_busy, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("coll_rereq", rf_req, 1);

        // Reset asserted asynchronously while waiting for done.
        $display("[TB] reset during wait");
        doReset(16'd3);
        for (int k = 1; k <= 3; k++) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rstwait_busy_before", rf_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstwait_busy", rf_busy, 0);
        checkOutput("rstwait_start", array_rf_start, 0);
        checkOutput("rstwait_req", rf_req, 0);
        checkOutput("rstwait_debt", rf_debt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rstwait_stray_done_debt", rf_debt, 0);
        checkOutput("rstwait_stray_done_busy", rf_busy, 0);

        // Zero interval never ticks.
        $display("[TB] zero interval");
        doReset(16'd0);
        sawReq = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            if (rf_req || rf_debt != 4'd0) sawReq = 1'b1;
        end
        checkOutput("zero_no_req", sawReq, 0);
        checkOutput("zero_debt", rf_debt, 0);

        // Interval of 1 ticks on every enabled cycle.
        doReset(16'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("one_tick1", rf_debt, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("one_tick3", rf_debt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
